// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: width, tap mask, checker states and the next-state polynomial.
package lfsr_pkg;

  localparam int                LFSR_W    = 3;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 3'b110;

  typedef enum logic [1:0] {IDLE, SYNC, TRACK, ERROR} chk_state_e;

  // Fibonacci step: shift left, feedback parity of tapped bits into the LSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q,
                                                  input logic [LFSR_W-1:0] taps);
    return {q[LFSR_W-2:0], ^(q & taps)};
  endfunction

endpackage

// File: rtl/lfsr_seq_checker_if.sv
// Generator-to-checker bus: load/seed/prnum in, status out.
// Snapshot signals exist only when LFSR_CHK_SNAPSHOT_EN is defined.
interface lfsr_seq_checker_if import lfsr_pkg::*; #(
  parameter int W     = LFSR_W,
  parameter int CNT_W = 4
);
  logic             load;
  logic [W-1:0]     seed;
  logic [W-1:0]     prnum;
  logic             locked;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             err_mismatch;
  logic             err_lockup;
  logic             busy;
`ifdef LFSR_CHK_SNAPSHOT_EN
  logic [W-1:0]     exp_snap;
  logic [W-1:0]     act_snap;

  modport master (output load, seed, prnum,
                  input  locked, period, period_valid, err_mismatch, err_lockup, busy,
                         exp_snap, act_snap);
  modport slave  (input  load, seed, prnum,
                  output locked, period, period_valid, err_mismatch, err_lockup, busy,
                         exp_snap, act_snap);
`else
  modport master (output load, seed, prnum,
                  input  locked, period, period_valid, err_mismatch, err_lockup, busy);
  modport slave  (input  load, seed, prnum,
                  output locked, period, period_valid, err_mismatch, err_lockup, busy);
`endif
endinterface

// File: rtl/lfsr_next_calc.sv
// Combinational LFSR predictor; the single place the polynomial is evaluated.
module lfsr_next_calc import lfsr_pkg::*; #(
  parameter int           W    = LFSR_W,
  parameter logic [W-1:0] TAPS = LFSR_TAPS
) (
  input  logic [W-1:0] q,
  output logic [W-1:0] q_next
);
  assign q_next = lfsr_next(q, TAPS);
endmodule

// File: rtl/lfsr_seq_checker.sv
// Predicts the generator stream, measures its period, flags mismatch/lock-up.
// Optional LFSR_CHK_SNAPSHOT_EN adds first-error expected/actual snapshots.
module lfsr_seq_checker import lfsr_pkg::*; #(
  parameter int           W     = LFSR_W,
  parameter logic [W-1:0] TAPS  = LFSR_TAPS,
  parameter int           CNT_W = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  lfsr_seq_checker_if.slave chk
);
  localparam logic [CNT_W-1:0] FULL_PERIOD = CNT_W'((1 << W) - 1);

  chk_state_e       state_q, state_d;
  logic [W-1:0]     ref_seed_q, ref_seed_d, pred_q, pred_d, nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic             locked_q, locked_d, pv_q, pv_d;
  logic             err_m_q, err_m_d, err_l_q, err_l_d;
`ifdef LFSR_CHK_SNAPSHOT_EN
  logic [W-1:0]     exp_q, exp_d, act_q, act_d;
`endif

  lfsr_next_calc #(.W(W), .TAPS(TAPS)) u_next (.q(chk.prnum), .q_next(nxt));

  always_comb begin
    state_d    = state_q;
    ref_seed_d = ref_seed_q;
    pred_d     = pred_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    locked_d   = locked_q;
    pv_d       = 1'b0;
    err_m_d    = err_m_q;
    err_l_d    = err_l_q;
`ifdef LFSR_CHK_SNAPSHOT_EN
    exp_d      = exp_q;
    act_d      = act_q;
`endif
    if (chk.load) begin
      ref_seed_d = chk.seed;
      locked_d   = 1'b0;
      err_m_d    = 1'b0;
      err_l_d    = 1'b0;
      cnt_d      = '0;
`ifdef LFSR_CHK_SNAPSHOT_EN
      exp_d      = chk.seed;
      act_d      = '0;
`endif
      if (chk.seed == '0) begin
        err_l_d = 1'b1;
        state_d = ERROR;
      end else begin
        state_d = SYNC;
      end
    end else begin
      case (state_q)
        SYNC: begin
          if (chk.prnum == ref_seed_q) begin
            pred_d  = nxt;
            cnt_d   = CNT_W'(1);
            state_d = TRACK;
          end else begin
            err_l_d = (chk.prnum == '0);
            err_m_d = (chk.prnum != '0);
            state_d = ERROR;
`ifdef LFSR_CHK_SNAPSHOT_EN
            exp_d   = ref_seed_q;
            act_d   = chk.prnum;
`endif
          end
        end
        TRACK: begin
          // Lock-up takes precedence over mismatch; a saturated count means the seed never recurred.
          if (chk.prnum == '0 || chk.prnum != pred_q ||
              (chk.prnum != ref_seed_q && cnt_q == '1)) begin
            err_l_d  = (chk.prnum == '0);
            err_m_d  = (chk.prnum != '0);
            locked_d = 1'b0;
            state_d  = ERROR;
`ifdef LFSR_CHK_SNAPSHOT_EN
            exp_d    = pred_q;
            act_d    = chk.prnum;
`endif
          end else begin
            pred_d = nxt;
            if (chk.prnum == ref_seed_q) begin
              period_d = cnt_q;
              pv_d     = 1'b1;
              cnt_d    = CNT_W'(1);
              locked_d = (cnt_q == FULL_PERIOD);
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ERROR:   locked_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      state_q    <= IDLE;
      ref_seed_q <= '0;
      pred_q     <= '0;
      cnt_q      <= '0;
      period_q   <= '0;
      locked_q   <= 1'b0;
      pv_q       <= 1'b0;
      err_m_q    <= 1'b0;
      err_l_q    <= 1'b0;
`ifdef LFSR_CHK_SNAPSHOT_EN
      exp_q      <= '0;
      act_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ref_seed_q <= ref_seed_d;
      pred_q     <= pred_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      locked_q   <= locked_d;
      pv_q       <= pv_d;
      err_m_q    <= err_m_d;
      err_l_q    <= err_l_d;
`ifdef LFSR_CHK_SNAPSHOT_EN
      exp_q      <= exp_d;
      act_q      <= act_d;
`endif
    end
  end

  assign chk.locked       = locked_q;
  assign chk.period       = period_q;
  assign chk.period_valid = pv_q;
  assign chk.err_mismatch = err_m_q;
  assign chk.err_lockup   = err_l_q;
  assign chk.busy         = (state_q == SYNC) || (state_q == TRACK);
`ifdef LFSR_CHK_SNAPSHOT_EN
  assign chk.exp_snap     = exp_q;
  assign chk.act_snap     = act_q;
`endif

endmodule

// File: doc/lfsr_seq_checker.md
Name: lfsr_seq_checker

Overview:
- Downstream monitor for the 3-bit Fibonacci LFSR pseudo-random generator.
- Consumes the generator's load strobe, seed and prNUM stream.
- Predicts each next value, measures the sequence period and flags mismatch or lock-up.
- Feeds status LEDs and the self-test logic in the lab top level.

Parameters:
W, 3, LFSR width (prnum/seed width)
TAPS, 3'b110, feedback tap mask; next = {q[W-2:0], ^(q & TAPS)}
CNT_W, 4, period counter width; saturates at 2^CNT_W-1

Ports:
sys_clk  in  1  clock, all state updates on rising edge
sys_rst_n  in  1  reset, asynchronous, active-high (state cleared while sys_rst_n=1)
load  in  1  generator seed-load strobe (same cycle the generator samples its load input)
seed  in  W  seed presented to the generator with load
prnum  in  W  generator output
locked  out  1  full maximal period (2^W-1) observed with no error since last load
period  out  CNT_W  last measured period in clocks
period_valid  out  1  one-cycle pulse when period updates
err_mismatch  out  1  sticky: prnum differed from prediction
err_lockup  out  1  sticky: all-zero seed or all-zero prnum seen
busy  out  1  high in SYNC or TRACK

Behaviour:
- Reset: state=IDLE; locked, period, period_valid, err_mismatch, err_lockup, busy all 0; ref_seed=0, pred=0, cnt=0.
- FSM states: IDLE, SYNC, TRACK, ERROR.
- load=1 has priority in every state:
  - ref_seed<=seed; clear locked, err_*, cnt.
  - If seed==0: err_lockup<=1, go ERROR; else go SYNC.
- SYNC (one cycle after load; prnum must equal seed):
  - prnum==ref_seed: pred<=next(prnum), cnt<=1, go TRACK.
  - prnum==0: err_lockup<=1, go ERROR.
  - Otherwise: err_mismatch<=1, go ERROR.
- TRACK, each edge:
  - prnum==0: err_lockup<=1, go ERROR (checked before mismatch).
  - prnum!=pred: err_mismatch<=1, go ERROR.
  - Otherwise pred<=next(prnum), then:
    - If prnum==ref_seed: period<=cnt, period_valid<=1, cnt<=1; locked<=1 iff cnt==2^W-1.
    - Else cnt<=cnt+1, saturating at all-ones.
  - Saturated cnt with seed not yet seen: err_mismatch<=1, go ERROR.
- ERROR: hold all flags and period; locked=0; leave only on load or reset.
- IDLE: no checking; prnum ignored.
- period_valid is registered, high exactly one cycle, never high in ERROR/IDLE.
- Latency: a mismatch on the prnum sampled at edge N raises err_* after edge N.
- Reset asserted mid-TRACK: outputs clear asynchronously; checking resumes only after the next load.

Optional Feature:
- Macro LFSR_CHK_SNAPSHOT_EN.
- Defined: adds outputs exp_snap[W-1:0] and act_snap[W-1:0].
  - Capture pred and prnum on the first error after a load.
  - Hold until the next load or reset; reset value 0.
  - For a lock-up error, exp_snap=pred (ref_seed when the error occurs in SYNC) and act_snap=0.
- Undefined: ports and registers absent; all other behaviour identical.

Decomposition:
- Package lfsr_pkg:
  - LFSR_W=3, LFSR_TAPS=3'b110.
  - State enum {IDLE, SYNC, TRACK, ERROR}.
  - Function lfsr_next(q, taps).
- Sub-module lfsr_next_calc: combinational predictor, instantiated once. The generator and checker share it so the polynomial is defined in one place.

Test Plan:
- Reset, then load=1 with seed=001 for one cycle, then feed 001,010,101,011,111,110,100,001,010 -> busy=1 from the cycle after load; period_valid pulses once at the second 001 with period=7, locked=1, err_*=0.
- Same stream but replace 011 with 111 -> err_mismatch=1 after that edge, state ERROR, locked=0, period unchanged; with LFSR_CHK_SNAPSHOT_EN, exp_snap=011 and act_snap=111.
- load with seed=000 -> err_lockup=1 after the edge, ERROR, busy=0.
- Locked on seed 001, then prnum forced to 000 -> err_lockup=1, locked=0.
- Tracking, then load with seed=110 and feed 110,100,001,010,101,011,111,110 -> flags clear on load, period=7, locked=1.
- Assert sys_rst_n=1 mid-TRACK, between clock edges -> all outputs 0 immediately (asynchronous); prnum ignored until the next load.
